atme_candidate_gen: RTL and testbench
=====================================

Name: atme_candidate_gen

Overview:
Candidate-vector generator for the ATME block-matching datapath. It sits directly downstream of the Update (LFSR update-vector) stage. Once per block it samples the 6-bit update vector and combines it with the spatial and temporal predictor vectors. It then streams four clamped candidate motion vectors to the SAD/match stage over a valid/ready handshake. It also pulses the Update stage enable so that a fresh random update vector is ready for the next block.

Parameters:
VW, 8, width of each signed vector component (two's complement) on predictor and candidate ports
RANGE, 16, search-range limit; every candidate component is saturated to [-RANGE, +RANGE]; must satisfy RANGE <= 2^(VW-1)-1

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  per-block request; accepted only in IDLE
sp_x  in  VW  spatial predictor, x component, signed
sp_y  in  VW  spatial predictor, y component, signed
tp_x  in  VW  temporal predictor, x component, signed
tp_y  in  VW  temporal predictor, y component, signed
uvec  in  6  update vector from Update stage: [2:0] = x, [5:3] = y, each 3-bit signed
upd_en  out  1  advance pulse to Update stage enable
busy  out  1  high from accepted start until last candidate accepted
cand_valid  out  1  candidate outputs valid
cand_ready  in  1  downstream accepts the candidate when valid and ready are both high
cand_x  out  VW  candidate x, signed, clamped
cand_y  out  VW  candidate y, signed, clamped
cand_idx  out  2  index of the current candidate, 0..3
cand_last  out  1  high while candidate 3 is presented
done  out  1  one-cycle pulse after candidate 3 is accepted

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: upd_en, busy, cand_valid, cand_x, cand_y, cand_idx, cand_last, done.
  - Latched predictor and update registers go to 0.
  - Reset has the same effect mid-stream; the in-flight block is abandoned and done does not pulse.
- States: IDLE, EMIT.
- IDLE:
  - When start==1 at edge T, latch sp, tp and uvec.
  - Register candidate 0 onto cand_x/cand_y and set cand_idx=0.
  - Set cand_valid=1 and busy=1; go to EMIT.
  - start while in EMIT is ignored and is not queued.
- upd_en is high for exactly the one cycle after the accepting edge T.
  - The Update LFSR therefore advances once per block, after uvec has been sampled.
- Candidate order, using latched values and u = sign-extended uvec components:
  - idx0 = clamp(sp)
  - idx1 = clamp(sp + u)
  - idx2 = clamp(tp + u)
  - idx3 = (0, 0)
- Arithmetic:
  - Sign-extend each 3-bit u component and each VW-bit predictor component to VW+1 bits before adding.
  - Saturate the sum to [-RANGE, +RANGE], then truncate to VW bits.
  - Predictor inputs outside the range are also clamped at idx0.
- EMIT handshake:
  - cand_x, cand_y, cand_idx and cand_last hold stable while cand_valid && !cand_ready.
  - On a cycle with cand_valid && cand_ready and idx<3: load candidate idx+1 at that edge, so there are no bubbles and one candidate is accepted per cycle under continuous ready.
  - On acceptance at idx==3: go to IDLE, drop cand_valid and busy, and pulse done for one cycle.
- cand_last = (cand_idx==3) && cand_valid.
- Latency:
  - start at edge T gives the first candidate valid in cycle T+1.
  - With cand_ready held high, done pulses in cycle T+5.
  - A new start is accepted no earlier than the done cycle.
- No combinational path exists from any input to any output.

Test Plan:
- Reset, then hold reset=0 for 3 cycles with start=1 → all outputs stay 0 and upd_en never pulses.
- sp=(5,-3), tp=(-7,2), uvec=6'b111101 (u=(-3,-1)), cand_ready=1 → candidates (5,-3), (2,-4), (-10,1), (0,0) on idx 0..3 in consecutive cycles. upd_en is one cycle at T+1, done at T+5, busy for 4 cycles.
- Clamp case: tp=(15,-16), uvec=6'b110011 (u=(3,-2)) → idx2 = (16,-16). Also sp=(20,-20) → idx0 = (16,-16).
- Backpressure: cand_ready low for 3 cycles during idx1 → cand_x/y/idx stay stable and valid stays high; sequence resumes with idx2 after ready rises, and done still pulses exactly once.
- start asserted during EMIT with a different sp → ignored, and the current candidates are unchanged. Then reset=0 mid-idx2 → next cycle all outputs are 0, no done pulse, and the next start begins at idx0.
- Back-to-back blocks: start held high continuously → second block begins in the cycle after done with newly sampled uvec; upd_en pulses once per block.

Source files
------------

// File: rtl/atme_candidate_gen_if.sv
// Candidate stream bus from the ATME candidate generator to the SAD/match stage.
//   cand_valid : candidate fields valid
//   cand_ready : consumer accepts when valid && ready
//   cand_x/y   : signed, clamped candidate components (VW bits)
//   cand_idx   : candidate index 0..3
//   cand_last  : high while candidate 3 is presented
interface atme_candidate_gen_if #(
  parameter int unsigned VW = 8
);
  logic          cand_valid;
  logic          cand_ready;
  logic [VW-1:0] cand_x;
  logic [VW-1:0] cand_y;
  logic [1:0]    cand_idx;
  logic          cand_last;

  modport master (
    output cand_valid, cand_x, cand_y, cand_idx, cand_last,
    input  cand_ready
  );

  modport slave (
    input  cand_valid, cand_x, cand_y, cand_idx, cand_last,
    output cand_ready
  );
endinterface

// File: rtl/atme_candidate_gen.sv
// ATME candidate-vector generator. Per block, samples the 6-bit LFSR update
// vector plus spatial/temporal predictors and streams four clamped candidates
// (sp, sp+u, tp+u, zero) over a valid/ready handshake.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   start           : per-block request, honoured only when idle
//   sp_x/sp_y       : spatial predictor (signed, VW bits)
//   tp_x/tp_y       : temporal predictor (signed, VW bits)
//   uvec            : update vector, [2:0]=x, [5:3]=y, 3-bit signed each
//   upd_en          : one-cycle advance pulse to the Update stage
//   busy            : block in progress
//   done            : one-cycle pulse after candidate 3 is accepted
//   cand            : candidate stream (master side)
module atme_candidate_gen #(
  parameter int unsigned VW    = 8,
  parameter int unsigned RANGE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VW-1:0]        sp_x,
  input  logic [VW-1:0]        sp_y,
  input  logic [VW-1:0]        tp_x,
  input  logic [VW-1:0]        tp_y,
  input  logic [5:0]           uvec,
  output logic                 upd_en,
  output logic                 busy,
  output logic                 done,
  atme_candidate_gen_if.master cand
);

  localparam int unsigned SW = VW + 1;
  localparam int unsigned UW = 3;

  typedef logic signed [SW-1:0] sum_t;

  localparam sum_t RMAX = sum_t'(RANGE);
  localparam sum_t RMIN = -RMAX;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Sign-extend a predictor component to the widened sum width.
  function automatic sum_t sext_v(input logic [VW-1:0] v);
    return sum_t'({v[VW-1], v});
  endfunction

  // Sign-extend a 3-bit update component to the widened sum width.
  function automatic sum_t sext_u(input logic [UW-1:0] v);
    return sum_t'({{(SW-UW){v[UW-1]}}, v});
  endfunction

  // Saturate to [-RANGE, +RANGE]; the result then fits VW bits.
  function automatic logic [VW-1:0] sat(input sum_t s);
    sum_t r;
    r = s;
    if (s > RMAX) begin
      r = RMAX;
    end else if (s < RMIN) begin
      r = RMIN;
    end
    return r[VW-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [VW-1:0] spx_q, spx_d, spy_q, spy_d;
  logic [VW-1:0] tpx_q, tpx_d, tpy_q, tpy_d;
  logic [UW-1:0] ux_q, ux_d, uy_q, uy_d;
  logic          valid_q, valid_d;
  logic [VW-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]    idx_q, idx_d;
  logic          last_q, last_d;
  logic          upd_en_q, upd_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Candidates 1 and 2 built from the latched block operands.
  logic [VW-1:0] c1x, c1y, c2x, c2y;
  always_comb begin
    c1x = sat(sext_v(spx_q) + sext_u(ux_q));
    c1y = sat(sext_v(spy_q) + sext_u(uy_q));
    c2x = sat(sext_v(tpx_q) + sext_u(ux_q));
    c2y = sat(sext_v(tpy_q) + sext_u(uy_q));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    spx_d    = spx_q;
    spy_d    = spy_q;
    tpx_d    = tpx_q;
    tpy_d    = tpy_q;
    ux_d     = ux_q;
    uy_d     = uy_q;
    valid_d  = valid_q;
    x_d      = x_q;
    y_d      = y_q;
    idx_d    = idx_q;
    last_d   = last_q;
    busy_d   = busy_q;
    upd_en_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          spx_d    = sp_x;
          spy_d    = sp_y;
          tpx_d    = tp_x;
          tpy_d    = tp_y;
          ux_d     = uvec[2:0];
          uy_d     = uvec[5:3];
          x_d      = sat(sext_v(sp_x));
          y_d      = sat(sext_v(sp_y));
          idx_d    = 2'd0;
          last_d   = 1'b0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          upd_en_d = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (valid_q && cand.cand_ready) begin
          if (idx_q == 2'd3) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // Load the following candidate on the accepting edge: no bubbles.
            idx_d  = idx_q + 2'd1;
            last_d = (idx_q == 2'd2);
            case (idx_q)
              2'd0: begin
                x_d = c1x;
                y_d = c1y;
              end
              2'd1: begin
                x_d = c2x;
                y_d = c2y;
              end
              default: begin
                x_d = '0;
                y_d = '0;
              end
            endcase
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      spx_q    <= '0;
      spy_q    <= '0;
      tpx_q    <= '0;
      tpy_q    <= '0;
      ux_q     <= '0;
      uy_q     <= '0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      idx_q    <= 2'd0;
      last_q   <= 1'b0;
      upd_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      spx_q    <= spx_d;
      spy_q    <= spy_d;
      tpx_q    <= tpx_d;
      tpy_q    <= tpy_d;
      ux_q     <= ux_d;
      uy_q     <= uy_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      upd_en_q <= upd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign upd_en          = upd_en_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign cand.cand_valid = valid_q;
  assign cand.cand_x     = x_q;
  assign cand.cand_y     = y_q;
  assign cand.cand_idx   = idx_q;
  assign cand.cand_last  = last_q;

endmodule

// File: tb/tb_atme_candidate_gen.sv
// Directed bench for atme_candidate_gen with a scoreboard of expected candidates.
module tb_atme_candidate_gen;

  localparam int unsigned VW    = 8;
  localparam int          RANGE = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [VW-1:0] sp_x, sp_y, tp_x, tp_y;
  logic [5:0]    uvec;
  logic          upd_en, busy, done;

  atme_candidate_gen_if #(.VW(VW)) bif ();

  atme_candidate_gen #(.VW(VW), .RANGE(RANGE)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sp_x   (sp_x),
    .sp_y   (sp_y),
    .tp_x   (tp_x),
    .tp_y   (tp_y),
    .uvec   (uvec),
    .upd_en (upd_en),
    .busy   (busy),
    .done   (done),
    .cand   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int idx;
    int last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v > RANGE) return RANGE;
    if (v < -RANGE) return -RANGE;
    return v;
  endfunction

  // Expected candidates for one block, queued when its start is sampled.
  task automatic push_block(input int spx, input int spy, input int tpx, input int tpy,
                            input logic [5:0] uv);
    logic signed [2:0] tx, ty;
    int ux, uy;
    exp_t e;
    tx = uv[2:0];
    ty = uv[5:3];
    ux = int'(tx);
    uy = int'(ty);
    e.x = clampi(spx);      e.y = clampi(spy);      e.idx = 0; e.last = 0; q.push_back(e);
    e.x = clampi(spx + ux); e.y = clampi(spy + uy); e.idx = 1; e.last = 0; q.push_back(e);
    e.x = clampi(tpx + ux); e.y = clampi(tpy + uy); e.idx = 2; e.last = 0; q.push_back(e);
    e.x = 0;                e.y = 0;                e.idx = 3; e.last = 1; q.push_back(e);
  endtask

  task automatic set_pred(input int spx, input int spy, input int tpx, input int tpy);
    sp_x = VW'(spx);
    sp_y = VW'(spy);
    tp_x = VW'(tpx);
    tp_y = VW'(tpy);
  endtask

  // Sample at the falling edge; an observed handshake is scored against the queue.
  task automatic samp();
    exp_t e;
    @(negedge clk);
    if (reset && bif.cand_valid === 1'b1 && bif.cand_ready === 1'b1) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=unexpected_candidate expected=none");
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cand_x",    32'($signed(bif.cand_x)), e.x);
        chk("cand_y",    32'($signed(bif.cand_y)), e.y);
        chk("cand_idx",  32'(bif.cand_idx),        e.idx);
        chk("cand_last", 32'(bif.cand_last),       e.last);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"},  32'(bif.cand_valid), 0);
    chk({tag, "_busy"},   32'(busy),           0);
    chk({tag, "_upd_en"}, 32'(upd_en),         0);
    chk({tag, "_done"},   32'(done),           0);
    chk({tag, "_x"},      32'(bif.cand_x),     0);
    chk({tag, "_y"},      32'(bif.cand_y),     0);
    chk({tag, "_idx"},    32'(bif.cand_idx),   0);
    chk({tag, "_last"},   32'(bif.cand_last),  0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int nupd;
    reset = 1'b0;
    start = 1'b0;
    bif.cand_ready = 1'b0;
    uvec = '0;
    set_pred(0, 0, 0, 0);
    adv();

    // Reset held with start asserted: everything stays quiet.
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk_idle("rst_hold");
      adv();
    end
    start = 1'b0;
    reset = 1'b1;
    adv();

    // Nominal block with continuous ready.
    set_pred(5, -3, -7, 2);
    uvec = 6'b111101;
    bif.cand_ready = 1'b1;
    start = 1'b1;
    push_block(5, -3, -7, 2, 6'b111101);
    samp();
    chk("pre_busy", 32'(busy), 0);
    adv();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      samp();
      chk("nom_upd_en", 32'(upd_en),         (k == 1) ? 1 : 0);
      chk("nom_busy",   32'(busy),           (k <= 4) ? 1 : 0);
      chk("nom_valid",  32'(bif.cand_valid), (k <= 4) ? 1 : 0);
      chk("nom_done",   32'(done),           (k == 5) ? 1 : 0);
      adv();
    end
    chk("nom_drained", q.size(), 0);

    // Saturation at idx0 (out-of-range predictor) and on sums.
    set_pred(20, -20, 15, -16);
    uvec = 6'b110011;
    start = 1'b1;
    push_block(20, -20, 15, -16, 6'b110011);
    adv();
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 6; k++) begin
      samp();
      if (done === 1'b1) ndone++;
      adv();
    end
    chk("clamp_done_cnt", ndone, 1);
    chk("clamp_drained", q.size(), 0);

    // Backpressure for three cycles on idx1.
    set_pred(-9, 11, 4, -6);
    uvec = 6'b010001;
    start = 1'b1;
    push_block(-9, 11, 4, -6, 6'b010001);
    adv();
    start = 1'b0;
    samp();
    adv();
    bif.cand_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      samp();
      chk("bp_valid", 32'(bif.cand_valid), 1);
      chk("bp_idx",   32'(bif.cand_idx),   1);
      chk("bp_x",     32'($signed(bif.cand_x)), -9 + 1);
      chk("bp_y",     32'($signed(bif.cand_y)), 11 + 2);
      adv();
    end
    bif.cand_ready = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      samp();
      if (done === 1'b1) ndone++;
      adv();
    end
    chk("bp_done_cnt", ndone, 1);
    chk("bp_drained", q.size(), 0);

    // start during EMIT is ignored; then reset mid-idx2.
    set_pred(3, -4, 6, 7);
    uvec = 6'b001010;
    bif.cand_ready = 1'b0;
    start = 1'b1;
    push_block(3, -4, 6, 7, 6'b001010);
    adv();
    set_pred(-12, 9, 0, 0);
    uvec = 6'b111111;
    for (int k = 0; k < 2; k++) begin
      samp();
      chk("ign_idx", 32'(bif.cand_idx), 0);
      chk("ign_x",   32'($signed(bif.cand_x)), 3);
      chk("ign_y",   32'($signed(bif.cand_y)), -4);
      adv();
    end
    start = 1'b0;
    bif.cand_ready = 1'b1;
    samp();
    adv();
    samp();
    adv();
    bif.cand_ready = 1'b0;
    samp();
    chk("mid_idx2", 32'(bif.cand_idx), 2);
    reset = 1'b0;
    adv();
    reset = 1'b1;
    samp();
    chk_idle("mid_rst");
    q.delete();
    adv();

    // Restart after the abandoned block, then back-to-back with start held.
    set_pred(-2, 1, 8, -8);
    uvec = 6'b000111;
    bif.cand_ready = 1'b1;
    start = 1'b1;
    push_block(-2, 1, 8, -8, 6'b000111);
    adv();
    ndone = 0;
    nupd = 0;
    for (int k = 1; k <= 10; k++) begin
      uvec = 6'(k * 7 + 3);
      if (k == 5) push_block(-2, 1, 8, -8, 6'(k * 7 + 3));
      if (k == 10) start = 1'b0;
      samp();
      if (k == 1) chk("b2b_first_idx", 32'(bif.cand_idx), 0);
      chk("b2b_upd_en", 32'(upd_en), (k == 1 || k == 6) ? 1 : 0);
      chk("b2b_done",   32'(done),   (k == 5 || k == 10) ? 1 : 0);
      if (done === 1'b1) ndone++;
      if (upd_en === 1'b1) nupd++;
      adv();
    end
    chk("b2b_done_cnt", ndone, 2);
    chk("b2b_upd_cnt", nupd, 2);
    samp();
    chk("end_idle_busy", 32'(busy), 0);
    chk("end_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
